// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified-memory port arbiter: owner codes,
// default bus widths and the starvation counter width.
package mem_port_arbiter_pkg;

   localparam int AW_DEF = 10;
   localparam int DW_DEF = 32;
   localparam int WAIT_W = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2,
      OWN_DBG  = 2'd3
   } owner_e;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Per-port denied-cycle counter. Saturates at MAX_WAIT, which marks the port
// as starved so the arbiter promotes it above the base priority order.
module starve_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              i_req,
   input  logic              i_gnt,
   output logic [WAIT_W-1:0] o_count,
   output logic              o_starved
);

   localparam logic [WAIT_W-1:0] LP_MAX = WAIT_W'(MAX_WAIT);

   logic [WAIT_W-1:0] r_count;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_count <= '0;
      end else if (i_req && !i_gnt) begin
         if (r_count != LP_MAX) r_count <= r_count + 1'b1;
      end else begin
         r_count <= '0;
      end
   end

   assign o_count   = r_count;
   assign o_starved = (r_count == LP_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF / DM / DBG onto one single-port memory with 1-cycle read
// latency, returns read data with a per-port registered valid, drives CPU stall.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int DW       = DW_DEF,
   parameter int MAX_WAIT = 4
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_gnt,
   output logic          dbg_rvalid,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [1:0]    owner,
   output logic          cpu_stall
);

   logic [WAIT_W-1:0] w_if_wait, w_dm_wait;
   logic              w_if_starved, w_dm_starved;
   owner_e            w_own;
   logic              r_if_rvalid, r_dm_rvalid, r_dbg_rvalid;

   starve_counter #(.MAX_WAIT(MAX_WAIT)) u_if_cnt (
      .Clk      (Clk),
      .Reset    (Reset),
      .i_req    (if_req),
      .i_gnt    (if_gnt),
      .o_count  (w_if_wait),
      .o_starved(w_if_starved)
   );

   starve_counter #(.MAX_WAIT(MAX_WAIT)) u_dm_cnt (
      .Clk      (Clk),
      .Reset    (Reset),
      .i_req    (dm_req),
      .i_gnt    (dm_gnt),
      .o_count  (w_dm_wait),
      .o_starved(w_dm_starved)
   );

   // Starved ports jump ahead of DBG; otherwise DBG > DM > IF.
   always_comb begin
      w_own = OWN_NONE;
      if (!Reset) begin
         if (if_req && w_if_starved)      w_own = OWN_IF;
         else if (dm_req && w_dm_starved) w_own = OWN_DM;
         else if (dbg_req)                w_own = OWN_DBG;
         else if (dm_req)                 w_own = OWN_DM;
         else if (if_req)                 w_own = OWN_IF;
      end
   end

   assign if_gnt  = (w_own == OWN_IF);
   assign dm_gnt  = (w_own == OWN_DM);
   assign dbg_gnt = (w_own == OWN_DBG);
   assign owner   = w_own;
   assign mem_en  = (w_own != OWN_NONE);

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (w_own)
         OWN_IF:  mem_addr = if_addr;
         OWN_DM: begin
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
         end
         OWN_DBG: begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
         end
         default: ;
      endcase
   end

   assign cpu_stall = !Reset && ((if_req && !if_gnt) || (dm_req && !dm_gnt));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_if_rvalid  <= 1'b0;
         r_dm_rvalid  <= 1'b0;
         r_dbg_rvalid <= 1'b0;
      end else begin
         r_if_rvalid  <= if_gnt;
         r_dm_rvalid  <= dm_gnt && !dm_we;
         r_dbg_rvalid <= dbg_gnt && !dbg_we;
      end
   end

   // Masking with Reset drops a read whose return lands in the first reset cycle.
   assign if_rvalid  = r_if_rvalid  && !Reset;
   assign dm_rvalid  = r_dm_rvalid  && !Reset;
   assign dbg_rvalid = r_dbg_rvalid && !Reset;
   assign rdata      = mem_rdata;

   a_wait_bounded : assert property (@(posedge Clk) disable iff (Reset)
      (w_if_wait <= WAIT_W'(MAX_WAIT)) && (w_dm_wait <= WAIT_W'(MAX_WAIT)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random + directed bench for mem_port_arbiter against a cycle-level
// behavioural model with a reference memory image.
module tb_mem_port_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int MW = 4;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          if_req, dm_req, dm_we, dbg_req, dbg_we;
   logic [AW-1:0] if_addr, dm_addr, dbg_addr;
   logic [DW-1:0] dm_wdata, dbg_wdata;
   logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, dbg_gnt, dbg_rvalid;
   logic [DW-1:0] rdata, mem_wdata, mem_rdata;
   logic          mem_en, mem_we, cpu_stall;
   logic [AW-1:0] mem_addr;
   logic [1:0]    owner;

   mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
      .Clk(Clk), .Reset(Reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
      .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .owner(owner), .cpu_stall(cpu_stall)
   );

   always #5 Clk = ~Clk;

   function automatic logic [DW-1:0] init_val(input int a);
      return 32'hA000_0000 | a;
   endfunction

   // Memory the DUT talks to.
   logic [DW-1:0] tbmem [int];
   always @(posedge Clk) begin
      if (mem_en) begin
         if (mem_we) tbmem[int'(mem_addr)] = mem_wdata;
         else mem_rdata <= tbmem.exists(int'(mem_addr)) ? tbmem[int'(mem_addr)]
                                                          : init_val(int'(mem_addr));
      end
   end

   // Model state
   logic [DW-1:0] ref_mem [int];
   int            if_w = 0, dm_w = 0, pend = 0;
   logic [DW-1:0] pend_data;
   int            e_own;
   logic          e_we;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata;

   int n_cmp = 0, n_bad = 0;
   int s_owner;
   logic s_if_gnt, s_dm_gnt, s_dbg_gnt, s_if_rv, s_dm_rv, s_stall, s_mem_en, s_mem_we;
   logic [AW-1:0] s_mem_addr;
   logic [DW-1:0] s_wdata, s_rdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] ref_rd(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   // One cycle: check outputs at negedge against the model, then advance the model.
   task automatic step();
      int e_rv;
      logic e_stall;
      @(negedge Clk);
      if (Reset) e_own = 0;
      else if (if_req && if_w == MW) e_own = 1;
      else if (dm_req && dm_w == MW) e_own = 2;
      else if (dbg_req) e_own = 3;
      else if (dm_req)  e_own = 2;
      else if (if_req)  e_own = 1;
      else e_own = 0;
      e_we    = (e_own == 2 && dm_we) || (e_own == 3 && dbg_we);
      e_addr  = (e_own == 1) ? if_addr : (e_own == 2) ? dm_addr : (e_own == 3) ? dbg_addr : '0;
      e_wdata = (e_own == 2) ? dm_wdata : dbg_wdata;
      e_stall = !Reset && ((if_req && e_own != 1) || (dm_req && e_own != 2));
      e_rv    = Reset ? 0 : pend;

      chk("owner",      32'(owner),      32'(e_own));
      chk("if_gnt",     32'(if_gnt),     32'(e_own == 1));
      chk("dm_gnt",     32'(dm_gnt),     32'(e_own == 2));
      chk("dbg_gnt",    32'(dbg_gnt),    32'(e_own == 3));
      chk("mem_en",     32'(mem_en),     32'(e_own != 0));
      chk("mem_we",     32'(mem_we),     32'(e_we));
      chk("cpu_stall",  32'(cpu_stall),  32'(e_stall));
      chk("if_rvalid",  32'(if_rvalid),  32'(e_rv == 1));
      chk("dm_rvalid",  32'(dm_rvalid),  32'(e_rv == 2));
      chk("dbg_rvalid", 32'(dbg_rvalid), 32'(e_rv == 3));
      if (e_own != 0) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      if (e_we)       chk("mem_wdata", mem_wdata, e_wdata);
      if (e_rv != 0)  chk("rdata", rdata, pend_data);

      s_owner = int'(owner); s_if_gnt = if_gnt; s_dm_gnt = dm_gnt; s_dbg_gnt = dbg_gnt;
      s_if_rv = if_rvalid; s_dm_rv = dm_rvalid; s_stall = cpu_stall; s_mem_en = mem_en;
      s_mem_we = mem_we; s_mem_addr = mem_addr; s_wdata = mem_wdata; s_rdata = rdata;

      @(posedge Clk);
      if (Reset) begin
         if_w = 0; dm_w = 0; pend = 0;
      end else begin
         if_w = (if_req && e_own != 1) ? ((if_w + 1 > MW) ? MW : if_w + 1) : 0;
         dm_w = (dm_req && e_own != 2) ? ((dm_w + 1 > MW) ? MW : dm_w + 1) : 0;
         pend = (e_own != 0 && !e_we) ? e_own : 0;
         if (pend != 0) pend_data = ref_rd(int'(e_addr));
         if (e_own != 0 && e_we) ref_mem[int'(e_addr)] = e_wdata;
      end
      #1;
   endtask

   task automatic idle();
      if_req = 0; dm_req = 0; dbg_req = 0;
   endtask

   task automatic pat(input string nm, input int n, input int exp [6]);
      for (int i = 0; i < n; i++) begin
         step();
         chk(nm, 32'(s_owner), 32'(exp[i]));
      end
   endtask

   initial begin
      Reset = 1; idle(); dm_we = 0; dbg_we = 0;
      if_addr = '0; dm_addr = '0; dbg_addr = 10'h3F0; dm_wdata = '0; dbg_wdata = '0;
      if_req = 1; dm_req = 1; dbg_req = 1;
      repeat (2) begin
         step();
         chk("rst_owner", 32'(s_owner), 0);
         chk("rst_mem_en", 32'(s_mem_en), 0);
      end
      Reset = 0;
      step(); chk("first_dbg", 32'(s_owner), 3);
      idle(); step();

      if_req = 1; if_addr = 10'h004;
      step(); chk("if_gnt_lit", 32'(s_if_gnt), 1); chk("if_addr_lit", 32'(s_mem_addr), 32'h4);
      chk("if_nostall", 32'(s_stall), 0);
      idle(); step(); chk("if_rv_lit", 32'(s_if_rv), 1); chk("if_rdata_lit", s_rdata, 32'hA000_0004);

      if_req = 1; if_addr = 10'h008; dm_req = 1; dm_we = 1; dm_addr = 10'h010; dm_wdata = 32'hDEADBEEF;
      step(); chk("dm_wr_gnt", 32'(s_dm_gnt), 1); chk("dm_wr_we", 32'(s_mem_we), 1);
      chk("dm_wr_data", s_wdata, 32'hDEADBEEF); chk("dm_wr_stall", 32'(s_stall), 1);
      dm_req = 0; step(); chk("if_after_dm", 32'(s_if_gnt), 1); chk("no_dm_rv", 32'(s_dm_rv), 0);
      idle(); step();

      dbg_req = 1; if_req = 1; pat("dbg_vs_if", 6, '{3, 3, 3, 3, 1, 3}); idle(); step();
      dbg_req = 1; dm_req = 1; dm_we = 0; pat("dbg_vs_dm", 6, '{3, 3, 3, 3, 2, 3}); idle(); step();
      dbg_req = 1; dm_req = 1; if_req = 1; pat("both_starve_a", 4, '{3, 3, 3, 3, 0, 0});
      dbg_req = 0; pat("both_starve_b", 2, '{1, 2, 0, 0, 0, 0}); idle(); step();

      dm_req = 1; dm_we = 0; dm_addr = 10'h010;
      step(); chk("dm_rd_gnt", 32'(s_dm_gnt), 1);
      Reset = 1; idle(); step(); chk("rv_suppressed", 32'(s_dm_rv), 0);
      Reset = 0; dbg_req = 1; if_req = 1; pat("post_rst", 5, '{3, 3, 3, 3, 1, 0}); idle(); step();

      for (int c = 0; c < 3000; c++) begin
         Reset = ($urandom_range(0, 199) == 0);
         if (!(if_req && !s_if_gnt && $urandom_range(0, 9) != 0)) begin
            if_req = ($urandom_range(0, 2) != 0); if_addr = AW'($urandom_range(0, 31));
         end
         if (!(dm_req && !s_dm_gnt && $urandom_range(0, 9) != 0)) begin
            dm_req = ($urandom_range(0, 1) != 0); dm_we = $urandom_range(0, 1) != 0;
            dm_addr = AW'($urandom_range(0, 31)); dm_wdata = $urandom;
         end
         if (!(dbg_req && !s_dbg_gnt)) begin
            dbg_req = ($urandom_range(0, 2) == 0); dbg_we = $urandom_range(0, 1) != 0;
            dbg_addr = AW'($urandom_range(0, 31)); dbg_wdata = $urandom;
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
